// File: rtl/dispensador_206.sv
// Drink/change dispenser: drives the vend motor and the 5c coin ejector for each request.
// Latency: motor/coin5 rise in the cycle after a request is sampled in IDLE; outputs are registered.
// Backpressure: none to the source; one request is buffered while busy, further ones are dropped and flagged on err.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   D1    - drink-release request (one request per high cycle)
//   T     - change code: 00 none, 01 5c, 10 10c, 11 20c
//   motor - drink-release actuator drive (registered)
//   coin5 - 5c coin ejector drive (registered)
//   busy  - FSM not in IDLE
//   done  - one-cycle completion pulse
//   err   - sticky overflow flag, cleared only by reset
module dispensador_206 #(
  parameter int MOTOR_CYC = 4,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       D1,
  input  logic [1:0] T,
  output logic       motor,
  output logic       coin5,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VEND  = 3'd1,
    EJ_HI = 3'd2,
    EJ_LO = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Terminal counts: each phase lasts parameter-value cycles, counting from 0.
  localparam logic [7:0] MOTOR_TC = 8'(MOTOR_CYC - 1);
  localparam logic [7:0] PULSE_TC = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_TC   = 8'(GAP_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] coins_q, coins_d;

  logic       pend_vld_q;
  logic       pend_vend_q;
  logic [2:0] pend_coins_q;
  logic       err_q;

  logic       motor_q, coin5_q;
  logic       motor_d, coin5_d;

  logic       req;
  logic [2:0] req_coins;

  logic       launch;
  logic       launch_vend;
  logic [2:0] launch_coins;

  assign req = D1 | (T != 2'b00);

  // 20c is returned as four 5c coins, so the counter needs three bits.
  always_comb begin
    req_coins = 3'd0;
    case (T)
      2'b01:   req_coins = 3'd1;
      2'b10:   req_coins = 3'd2;
      2'b11:   req_coins = 3'd4;
      default: req_coins = 3'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. In IDLE the buffered request always wins over a new one.
  always_comb begin
    state_d      = state_q;
    launch       = 1'b0;
    launch_vend  = 1'b0;
    launch_coins = 3'd0;
    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          launch       = 1'b1;
          launch_vend  = pend_vend_q;
          launch_coins = pend_coins_q;
        end else if (req) begin
          launch       = 1'b1;
          launch_vend  = D1;
          launch_coins = req_coins;
        end
        if (launch) begin
          state_d = launch_vend ? VEND : EJ_HI;
        end
      end
      VEND: begin
        if (cnt_q == MOTOR_TC) begin
          state_d = (coins_q != 3'd0) ? EJ_HI : FIN;
        end
      end
      EJ_HI: begin
        // coins_q still holds the coin being ejected; more remain only if it exceeds one.
        if (cnt_q == PULSE_TC) begin
          state_d = (coins_q > 3'd1) ? EJ_LO : FIN;
        end
      end
      EJ_LO: begin
        if (cnt_q == GAP_TC) begin
          state_d = EJ_HI;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Phase counter restarts on every state change, so it never runs past its terminal count.
  always_comb begin
    cnt_d   = 8'd0;
    coins_d = coins_q;
    if ((state_d == state_q) &&
        ((state_q == VEND) || (state_q == EJ_HI) || (state_q == EJ_LO))) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (launch) begin
      coins_d = launch_coins;
    end else if ((state_q == EJ_HI) && (cnt_q == PULSE_TC)) begin
      coins_d = coins_q - 3'd1;
    end
  end

  // Output logic: actuator drives follow the next state so they are registered yet
  // line up with the state they belong to.
  always_comb begin
    motor_d = (state_d == VEND);
    coin5_d = (state_d == EJ_HI);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 8'd0;
      coins_q <= 3'd0;
      motor_q <= 1'b0;
      coin5_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      coins_q <= coins_d;
      motor_q <= motor_d;
      coin5_q <= coin5_d;
    end
  end

  // Pending buffer and overflow flag. FIN counts as busy, so a request there is buffered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_q   <= 1'b0;
      pend_vend_q  <= 1'b0;
      pend_coins_q <= 3'd0;
      err_q        <= 1'b0;
    end else if (state_q == IDLE) begin
      // The buffered request launches now; a same-cycle request takes its slot.
      if (pend_vld_q) begin
        pend_vld_q <= req;
        if (req) begin
          pend_vend_q  <= D1;
          pend_coins_q <= req_coins;
        end
      end
    end else if (req) begin
      if (!pend_vld_q) begin
        pend_vld_q   <= 1'b1;
        pend_vend_q  <= D1;
        pend_coins_q <= req_coins;
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  assign motor = motor_q;
  assign coin5 = coin5_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FIN);
  assign err   = err_q;

endmodule

// File: tb/tb_dispensador_206.sv
module tb_dispensador_206;

  localparam int M = 4;
  localparam int P = 2;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d1  = 1'b0;
  logic [1:0] t   = 2'b00;
  logic       motor, coin5, busy, done, err;

  dispensador_206 #(.MOTOR_CYC(M), .PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk   (clk),
    .rst   (rst),
    .D1    (d1),
    .T     (t),
    .motor (motor),
    .coin5 (coin5),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit vend;
    int coins;
    int start;
  } job_t;

  job_t exp_q[$];

  // Reference model: job-level view (remaining busy cycles + one buffered request).
  int rem      = 0;
  bit pv       = 0;
  bit pvend    = 0;
  int pcoins   = 0;
  bit err_exp  = 0;
  bit m_req;
  int m_coins;

  function automatic int coins_of(logic [1:0] tt);
    return (tt == 2'd1) ? 1 : (tt == 2'd2) ? 2 : (tt == 2'd3) ? 4 : 0;
  endfunction

  function automatic int dur_of(bit v, int c);
    return (v ? M : 0) + c * P + ((c > 0) ? (c - 1) * G : 0) + 1;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req_v);
    n_assert++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req_v, cyc);
    end
  endtask

  task automatic launch(bit v, int c);
    job_t j;
    j.vend  = v;
    j.coins = c;
    j.start = cyc;
    exp_q.push_back(j);
    rem = dur_of(v, c);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem     = 0;
      pv      = 0;
      err_exp = 0;
      exp_q.delete();
    end else begin
      cyc++;
      m_req   = d1 || (t != 2'b00);
      m_coins = coins_of(t);
      if (rem == 0) begin
        if (pv) begin
          launch(pvend, pcoins);
          pv     = m_req;
          pvend  = d1;
          pcoins = m_coins;
        end else if (m_req) begin
          launch(d1, m_coins);
        end
      end else begin
        if (m_req) begin
          if (!pv) begin
            pv     = 1;
            pvend  = d1;
            pcoins = m_coins;
          end else begin
            err_exp = 1;
          end
        end
        rem--;
      end
    end
  end

  // Monitor: collect each busy run as a {motor,coin5,done} trace and score it at done.
  bit         in_job = 0;
  int         start_c;
  logic [2:0] obs[$];
  logic [2:0] ex[$];
  job_t       e;
  int         mism;

  always @(negedge clk) begin
    if (!rst) begin
      in_job = 0;
      obs.delete();
    end else begin
      check("motor_coin_excl", {31'd0, motor & coin5}, 0);
      check("err_flag", {31'd0, err}, {31'd0, err_exp});
      if (busy) begin
        if (!in_job) begin
          in_job  = 1;
          start_c = cyc;
          obs.delete();
        end
        obs.push_back({motor, coin5, done});
      end else begin
        check("idle_outputs", {29'd0, motor, coin5, done}, 0);
      end
      if (done) begin
        in_job = 0;
        check("job_expected", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          ex.delete();
          if (e.vend) for (int i = 0; i < M; i++) ex.push_back(3'b100);
          for (int c = 0; c < e.coins; c++) begin
            for (int i = 0; i < P; i++) ex.push_back(3'b010);
            if (c < e.coins - 1) for (int i = 0; i < G; i++) ex.push_back(3'b000);
          end
          ex.push_back(3'b001);
          mism = 0;
          for (int i = 0; i < obs.size() && i < ex.size(); i++)
            if (obs[i] !== ex[i]) mism++;
          check("job_start", start_c, e.start);
          check("busy_len", obs.size(), ex.size());
          check("trace_mismatch_cnt", mism, 0);
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(bit v, logic [1:0] tt);
    @(negedge clk);
    d1 = v;
    t  = tt;
    @(negedge clk);
    d1 = 0;
    t  = 2'b00;
  endtask

  task automatic drain();
    int b = 0;
    while ((rem != 0 || pv) && b < 500) begin
      @(negedge clk);
      b++;
    end
    check("drain_in_budget", {31'd0, b < 500}, 1);
    idle(3);
  endtask

  initial begin
    int k;
    int b;
    bit prev;
    bit seen;

    rst = 0;
    idle(3);
    check("reset_outputs", {27'd0, motor, coin5, busy, done, err}, 0);
    rst = 1;

    issue(1, 2'b00);  // drink only
    drain();
    issue(1, 2'b01);  // drink + 5c
    drain();
    issue(0, 2'b10);  // refund 10c
    drain();
    issue(1, 2'b11);  // drink + 20c
    drain();

    // Three requests one cycle apart: second queued, third dropped.
    issue(1, 2'b00);
    issue(0, 2'b01);
    issue(1, 2'b10);
    drain();
    check("err_sticky", {31'd0, err}, 1);
    idle(5);
    check("err_still_set", {31'd0, err}, 1);

    // Reset during the third coin pulse with a request pending.
    issue(1, 2'b11);
    issue(1, 2'b00);
    k    = 0;
    b    = 0;
    prev = 0;
    while (k < 3 && b < 200) begin
      @(negedge clk);
      if (coin5 && !prev) k++;
      prev = coin5;
      b++;
    end
    check("reached_third_pulse", k, 3);
    #2 rst = 0;
    #1 check("async_reset_clear", {27'd0, motor, coin5, busy, done, err}, 0);
    idle(2);
    rst = 1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | busy | motor | coin5;
    end
    check("no_resume_after_reset", {31'd0, seen}, 0);

    // Randomized traffic against the model.
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        d1 = 1'($urandom);
        t  = 2'($urandom);
      end else begin
        d1 = 0;
        t  = 2'b00;
      end
    end
    @(negedge clk);
    d1 = 0;
    t  = 2'b00;
    drain();
    check("all_jobs_seen", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d assertions, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dispensador_206.md
DISPENSADOR_206 -- requirements
Module: dispensador_206

Interface
REQ-001 Parameter MOTOR_CYC, default 4, number of cycles `motor` stays high per drink (range 1-255).
REQ-002 Parameter PULSE_CYC, default 2, number of cycles `coin5` stays high per 5-cent coin ejected (range 1-255).
REQ-003 Parameter GAP_CYC, default 2, number of low cycles between consecutive `coin5` pulses (range 1-255).
REQ-004 clk  input  1  single clock; all state is updated on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 D1  input  1  drink-release request from the vending FSM; one request per cycle it is high.
REQ-007 T  input  2  change code from the vending FSM: 00 none, 01 5c, 10 10c, 11 20c.
REQ-008 motor  output  1  drink-release actuator drive, registered.
REQ-009 coin5  output  1  5-cent coin ejector drive, registered.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 done  output  1  one-cycle pulse marking completion of a request.
REQ-012 err  output  1  sticky flag: a request was dropped because the pending buffer was full.

Function
REQ-013 Request event = (D1==1) OR (T!=00), sampled on each rising clk edge; every sampled cycle counts as one request {vend=D1, coins}.
REQ-014 Coin count mapping: T=01 gives 1 coin, T=10 gives 2, T=11 gives 4, T=00 gives 0; held in a 3-bit remaining-coin counter.
REQ-015 FSM states: IDLE, VEND, EJ_HI, EJ_LO, FIN.
REQ-016 IDLE launch: with a request to launch, go to VEND if vend=1, else to EJ_HI; load the phase counter and the coin count.
REQ-017 VEND: `motor`=1 for exactly MOTOR_CYC cycles, then go to EJ_HI if coins>0, else to FIN.
REQ-018 EJ_HI: `coin5`=1 for PULSE_CYC cycles, then decrement coins; go to EJ_LO if coins remain, else to FIN.
REQ-019 EJ_LO: `coin5`=0 for GAP_CYC cycles, then return to EJ_HI.
REQ-020 FIN: lasts one cycle with `done`=1, then returns to IDLE.
REQ-021 Latency: a request sampled at edge k in IDLE shows `motor` (or `coin5`) high in the cycle after edge k.
REQ-022 `busy` is high in every state except IDLE; `motor` and `coin5` are never high in the same cycle.
REQ-023 Pending buffer: one-deep, holding {vend, coins, valid}; a request sampled while busy is stored if valid=0.
REQ-024 Overflow: a request sampled while busy with valid=1 is dropped, the stored request is unchanged, and `err` is set to 1 until reset.
REQ-025 Launch priority in IDLE: the pending request launches first and valid clears; a request sampled in the same cycle is written into the buffer.
REQ-026 A request sampled in the FIN cycle is treated as a busy-time request (REQ-023/024).
REQ-027 Phase counters are 8-bit, with terminal count at parameter value minus 1, and must not wrap.

Reset
REQ-028 While rst=0, immediately and asynchronously: state=IDLE, motor=0, coin5=0, busy=0, done=0, err=0, pending valid=0, all counters 0.
REQ-029 Reset asserted mid-operation aborts the request and clears the pending buffer; no outputs resume after release.
REQ-030 The first request can be sampled on the first rising edge after rst returns to 1.

Verification
REQ-031 D1=1,T=00 for one cycle, defaults -> motor high 4 cycles, done pulse 1 cycle later, coin5 never high, busy high 5 cycles.
REQ-032 D1=1,T=01 -> motor 4 cycles, then coin5 high 2 cycles, then FIN; total busy 7 cycles.
REQ-033 D1=0,T=10 (refund) -> no motor; coin5 pattern 1,1,0,0,1,1; then done; busy 7 cycles.
REQ-034 D1=1,T=11 -> motor 4 cycles, then four coin5 pulses of 2 cycles each separated by 2-cycle gaps, then done.
REQ-035 Three one-cycle requests spaced 1 cycle apart while busy -> second is executed after the first, third is dropped, err=1 and stays 1.
REQ-036 rst driven low during the third coin5 pulse with a request pending -> outputs 0 at once; after release busy=0 and the pending request is never executed.
